// File: rtl/unpacked_serializer_pkg.sv
// rtl/unpacked_serializer_pkg.sv - shared constants and state type for the unpacked serializer
//
// Purpose : default element count and FSM state encoding shared by the
//           serializer and its storage interface.
// Contents: N_DEFAULT  - default number of unpacked elements (8)
//           ser_state_t - IDLE (accepting a load) / SHIFT (emitting elements)
package unpacked_serializer_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/unpacked_serializer_i_ser.sv
// rtl/unpacked_serializer_i_ser.sv - storage interface holding the captured unpacked word
//
// Purpose : holds the N captured elements of the word being serialized.
// Members : x [N] - one bit per element, written only by the serializer FSM
interface I_ser
    import unpacked_serializer_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic x [N];

endinterface

// File: rtl/unpacked_serializer.sv
// rtl/unpacked_serializer.sv - loads an unpacked bit array and emits it one element per transfer
//
// Purpose : captures i_data[0..N-1] on i_valid && o_ready, then presents the
//           elements in order 0..N-1 on o_bit with a valid/ready handshake.
// Ports   : i_clk       - clock, all state changes on posedge
//           i_rst       - synchronous active-high reset
//           i_valid     - i_data holds a word to load
//           i_data [N]  - unpacked word to serialize
//           o_ready     - block accepts a load this cycle (IDLE)
//           o_bit       - current serialized element
//           o_bitValid  - o_bit is valid (SHIFT)
//           i_bitReady  - consumer accepts o_bit this cycle
//           o_last      - o_bit is element N-1
module unpacked_serializer
    import unpacked_serializer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_data [N],
    output logic o_ready,
    output logic o_bit,
    output logic o_bitValid,
    input  logic i_bitReady,
    output logic o_last
);

    localparam int              IW       = $clog2(N);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

    I_ser #(.N(N)) u_store ();

    ser_state_t     r_state;
    logic [IW-1:0]  r_idx;
    logic           r_ready;
    logic           r_bit;
    logic           r_bit_valid;
    logic           r_last;

    logic [IW-1:0]  w_idx_next;
    logic           w_load;
    logic           w_xfer;

    assign w_idx_next = r_idx + 1'b1;
    // Loads are only possible in IDLE and transfers only in SHIFT, so a
    // final transfer coinciding with i_valid leaves one idle bubble.
    assign w_load     = (r_state == IDLE)  && i_valid;
    assign w_xfer     = (r_state == SHIFT) && i_bitReady;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_ready     <= 1'b1;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_last      <= 1'b0;
            foreach (u_store.x[i]) u_store.x[i] <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        foreach (u_store.x[i]) u_store.x[i] <= i_data[i];
                        r_state     <= SHIFT;
                        r_idx       <= '0;
                        r_ready     <= 1'b0;
                        r_bit       <= i_data[0];
                        r_bit_valid <= 1'b1;
                        r_last      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_xfer) begin
                        if (r_idx == LAST_IDX) begin
                            r_state     <= IDLE;
                            r_idx       <= '0;
                            r_ready     <= 1'b1;
                            r_bit       <= 1'b0;
                            r_bit_valid <= 1'b0;
                            r_last      <= 1'b0;
                        end else begin
                            // Output registers track the element idx is about to point at.
                            r_idx  <= w_idx_next;
                            r_bit  <= u_store.x[w_idx_next];
                            r_last <= (w_idx_next == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready    = r_ready;
    assign o_bit      = r_bit;
    assign o_bitValid = r_bit_valid;
    assign o_last     = r_last;

endmodule

// File: doc/unpacked_serializer.md
UNPACKED_SERIALIZER -- requirements
Module: unpacked_serializer

Interface
REQ-001 SHALL have parameter N, default 8: number of elements in the unpacked input array; N >= 2.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its posedge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port i_valid, input, 1 bit: i_data holds a word to load.
REQ-005 SHALL have port i_data, input, logic [N] unpacked: the word to serialize; typically fed from an upstream o_a [8] array port.
REQ-006 SHALL have port o_ready, output, 1 bit: the block accepts a load this cycle.
REQ-007 SHALL have port o_bit, output, 1 bit: current serialized element.
REQ-008 SHALL have port o_bitValid, output, 1 bit: o_bit is valid.
REQ-009 SHALL have port i_bitReady, input, 1 bit: the consumer accepts o_bit this cycle.
REQ-010 SHALL have port o_last, output, 1 bit: o_bit is element N-1.

Function
REQ-011 SHALL implement two states: IDLE and SHIFT.
REQ-012 SHALL drive o_ready = 1 only in IDLE; o_bitValid = 1 only in SHIFT.
REQ-013 Load SHALL occur on a posedge with i_valid && o_ready: all N elements are captured via a foreach loop over the storage array, the index is set to 0, and the state moves to SHIFT.
REQ-014 Latency SHALL be one cycle: if load happens at edge k, o_bitValid = 1 with o_bit = i_data[0] from edge k.
REQ-015 In SHIFT, o_bit SHALL equal stored element [idx], with elements emitted in order 0..N-1.
REQ-016 o_last SHALL be 1 iff state == SHIFT and idx == N-1.
REQ-017 Transfer SHALL occur on o_bitValid && i_bitReady; idx increments by 1 on each transfer.
REQ-018 The transfer with idx == N-1 SHALL move the state to IDLE and clear idx to 0.
REQ-019 With i_bitReady = 0, the block SHALL hold o_bit, idx and o_last stable, with no timeout.
REQ-020 i_valid while o_ready = 0 SHALL be ignored; the upstream holds i_valid and i_data.
REQ-021 If the last transfer and i_valid coincide, the load SHALL NOT occur that cycle; the load occurs on the following edge, giving exactly one idle bubble.
REQ-022 idx width SHALL be $clog2(N); idx never exceeds N-1, and no wrap-around occurs beyond the transition to IDLE.
REQ-023 Stored elements SHALL change only on load; i_data changes during SHIFT have no effect.

Reset
REQ-024 On i_rst = 1 at a posedge, the block SHALL set state = IDLE and idx = 0.
REQ-025 Outputs after reset SHALL be: o_ready = 1, o_bitValid = 0, o_last = 0, o_bit = 0.
REQ-026 Stored elements SHALL reset to 0 via foreach.
REQ-027 Reset mid-SHIFT SHALL abandon the word; any remaining bits are never emitted.
REQ-028 Reset SHALL take priority over a simultaneous load or transfer.

Structure
REQ-029 Storage SHALL be an unpacked array member `x [N]` of an interface instance inside the module, written only by always_ff.
REQ-030 A shared package SHALL hold the default N (8) and the state enum typedef {IDLE, SHIFT}.
REQ-031 SHALL have no sub-module, other than the storage interface I_ser (member x [N]).

Verification
REQ-032 Reset test: assert i_rst for 2 cycles, then release -> o_ready = 1, o_bitValid = 0, o_last = 0, o_bit = 0.
REQ-033 Basic shift test: load i_data = {1,0,1,1,0,0,1,0} (elements 0..7) with i_bitReady = 1 held -> o_bit sequence 1,0,1,1,0,0,1,0 on 8 consecutive cycles starting 1 cycle after load; o_last on the 8th cycle only; o_ready = 1 on the 9th.
REQ-034 Stall test: drop i_bitReady for 3 cycles at idx = 3 -> o_bit = element 3 held for 4 cycles; total 11 cycles to IDLE; no element lost or duplicated.
REQ-035 Back-to-back test: hold i_valid = 1 with a second word all ones -> second load one cycle after the first word's last transfer; 1-cycle bubble; then eight 1s.
REQ-036 Mid-reset test: pulse i_rst at idx = 5 -> next cycle IDLE with o_bitValid = 0; a new load then starts at element 0.
REQ-037 Ignored-load test: change i_data and pulse i_valid during SHIFT -> output sequence unchanged from the originally loaded word.
